// File: rtl/data_bus_arbiter_if.sv
// Bundle of per-channel request/flag inputs and grant/strobe outputs for the FIFO data bus arbiter.
// Channel bit mapping everywhere: [0]=fft, [1]=fir, [2]=iir.
interface data_bus_arbiter_if;
  logic [2:0]  get_req;
  logic [2:0]  put_req;
  logic [2:0]  empty;
  logic [2:0]  full;
  logic [2:0]  grant;
  logic        dir;
  logic        bus_oe;
  logic [2:0]  rd_en;
  logic [2:0]  wr_en;
  logic [15:0] xfer_cnt;

  modport master (
    output get_req, put_req, empty, full,
    input  grant, dir, bus_oe, rd_en, wr_en, xfer_cnt
  );

  modport slave (
    input  get_req, put_req, empty, full,
    output grant, dir, bus_oe, rd_en, wr_en, xfer_cnt
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin owner of a shared data bus across three FIFO channels, bursts of up to BURST_MAX beats.
// Grant registered 1 cycle after request; strobes are combinational and drop the same cycle a FIFO flag blocks.
module data_bus_arbiter #(
  parameter int BURST_MAX = 4
) (
  input logic                 clk,
  input logic                 rst,
  data_bus_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_TURN = 2'd2;
  localparam logic [3:0] BEAT_LAST = 4'(BURST_MAX - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_grant;
  logic        r_dir;
  logic [1:0]  r_last;
  logic [3:0]  r_beat;
  logic [15:0] r_xfer_cnt;

  logic [2:0]  w_get_elig;
  logic [2:0]  w_put_elig;
  logic [2:0]  w_any_elig;
  logic        w_xfer;
  logic        w_last_beat;
  logic        w_found;
  logic [1:0]  w_win;

  assign w_get_elig  = bus.get_req & ~bus.empty;
  assign w_put_elig  = bus.put_req & ~bus.full;
  assign w_any_elig  = w_get_elig | w_put_elig;
  assign w_last_beat = (r_beat == BEAT_LAST);

  // Beat qualifies on current flags, so a FIFO going full/empty this cycle suppresses the strobe.
  assign w_xfer = (r_state == S_OWN) && !rst &&
                  (r_dir ? |(w_put_elig & r_grant) : |(w_get_elig & r_grant));

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  always_comb begin
    logic [1:0] cand;
    w_found = 1'b0;
    w_win   = 2'd0;
    cand    = next_ch(r_last);
    for (int k = 0; k < 3; k++) begin
      if (!w_found && w_any_elig[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
      cand = next_ch(cand);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= 3'b000;
      r_dir      <= 1'b0;
      r_last     <= 2'd2;
      r_beat     <= 4'd0;
      r_xfer_cnt <= 16'd0;
    end else begin
      if (w_xfer) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
        r_beat     <= r_beat + 4'd1;
      end
      case (r_state)
        S_OWN: begin
          if (!w_xfer || w_last_beat) begin
            r_state <= (|w_any_elig) ? S_TURN : S_IDLE;
            r_grant <= 3'b000;
          end
        end
        default: begin
          // IDLE and TURN both arbitrate; TURN exists only to force one dead cycle between owners.
          if (w_found) begin
            r_state <= S_OWN;
            r_grant <= 3'b001 << w_win;
            r_dir   <= !w_get_elig[w_win];
            r_last  <= w_win;
            r_beat  <= 4'd0;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.dir      = r_dir;
  assign bus.bus_oe   = (r_state == S_OWN) && !r_dir;
  assign bus.rd_en    = (w_xfer && !r_dir) ? r_grant : 3'b000;
  assign bus.wr_en    = (w_xfer && r_dir) ? r_grant : 3'b000;
  assign bus.xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed scenarios followed by random traffic, every cycle checked against a transaction-level model.
module tb_data_bus_arbiter;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_bus_arbiter_if bus();

  data_bus_arbiter #(.BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 = nobody), its direction, beats so far, last winner, beat total.
  int          m_owner = -1;
  bit          m_dir   = 1'b0;
  int          m_beats = 0;
  int          m_last  = 2;
  logic [15:0] m_cnt   = 16'd0;
  bit          m_known = 1'b0;

  task automatic tick(input logic [2:0] g, input logic [2:0] p, input logic [2:0] e,
                      input logic [2:0] f, input logic r);
    logic [2:0] ge, pe, ae, egr, erd, ewr;
    bit ok;
    @(negedge clk);
    bus.get_req = g;
    bus.put_req = p;
    bus.empty   = e;
    bus.full    = f;
    rst         = r;
    #1;
    ge  = g & ~e;
    pe  = p & ~f;
    ae  = ge | pe;
    ok  = (m_owner >= 0) && !r && (m_dir ? pe[m_owner] : ge[m_owner]);
    egr = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    erd = (ok && !m_dir) ? egr : 3'b000;
    ewr = (ok && m_dir) ? egr : 3'b000;
    if (m_known) begin
      chk("grant",    16'(bus.grant), 16'(egr));
      chk("dir",      16'(bus.dir), 16'(m_dir));
      chk("bus_oe",   16'(bus.bus_oe), 16'((m_owner >= 0) && !m_dir));
      chk("rd_en",    16'(bus.rd_en), 16'(erd));
      chk("wr_en",    16'(bus.wr_en), 16'(ewr));
      chk("xfer_cnt", bus.xfer_cnt, m_cnt);
      chk("one_strobe", 16'($countones({bus.rd_en, bus.wr_en}) <= 1), 16'd1);
    end
    if (r) begin
      m_owner = -1; m_dir = 1'b0; m_beats = 0; m_last = 2; m_cnt = 16'd0; m_known = 1'b1;
    end else if (m_owner >= 0) begin
      if (ok) begin
        m_cnt++;
        m_beats++;
      end
      if (!ok || m_beats == BM) m_owner = -1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_last + 1 + k) % 3;
        if (ae[c]) begin
          m_owner = c; m_dir = !ge[c]; m_last = c; m_beats = 0;
          break;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.get_req = 3'b000; bus.put_req = 3'b000; bus.empty = 3'b000; bus.full = 3'b000;
    repeat (3) tick(3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
    // single fft getter: bursts of BM with a dead cycle between regrants
    repeat (20) tick(3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
    // all three getters rotate
    repeat (30) tick(3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
    repeat (3) tick(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    // fir putter, FIFO fills mid-burst
    for (int i = 0; i < 15; i++)
      tick(3'b000, 3'b010, 3'b000, (i >= 3) ? 3'b010 : 3'b000, 1'b0);
    // iir both directions; get wins until its FIFO empties
    for (int i = 0; i < 25; i++)
      tick(3'b100, 3'b100, (i >= 8) ? 3'b100 : 3'b000, 3'b000, 1'b0);
    // reset mid-burst
    repeat (4) tick(3'b011, 3'b000, 3'b000, 3'b000, 1'b0);
    tick(3'b011, 3'b000, 3'b000, 3'b000, 1'b1);
    repeat (10) tick(3'b011, 3'b000, 3'b000, 3'b000, 1'b0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] g, p, e, f;
      logic r;
      g = 3'($urandom);
      p = 3'($urandom);
      e = 3'($urandom) & 3'($urandom);
      f = 3'($urandom) & 3'($urandom);
      r = ($urandom_range(0, 299) == 0);
      tick(g, p, e, f, r);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
